// File: rtl/anti_theft_pkg.sv
// Shared encodings for the anti-theft controller: FSM states, LED status
// codes, timer width and the state-to-output decode.
package anti_theft_pkg;

  localparam int TIMER_W = 4;

  // 3-bit state encodings; 3'd7 is unused and recovers to ARMED.
  localparam logic [2:0] ST_ARMED             = 3'd0;
  localparam logic [2:0] ST_TRIGGERED         = 3'd1;
  localparam logic [2:0] ST_ALARM             = 3'd2;
  localparam logic [2:0] ST_DISARMED          = 3'd3;
  localparam logic [2:0] ST_WAIT_DRIVER_OUT   = 3'd4;
  localparam logic [2:0] ST_WAIT_DOORS_CLOSED = 3'd5;
  localparam logic [2:0] ST_ARMING            = 3'd6;

  // LED status codes; 2'b10 is never driven.
  localparam logic [1:0] STATUS_OFF   = 2'b00;
  localparam logic [1:0] STATUS_ON    = 2'b01;
  localparam logic [1:0] STATUS_BLINK = 2'b11;

  typedef struct packed {
    logic [1:0] status;
    logic       siren;
  } out_t;

  // Moore decode of the state register into the LED code and siren.
  function automatic out_t decode_state(input logic [2:0] st);
    out_t o;
    o.status = STATUS_BLINK;
    o.siren  = 1'b0;
    case (st)
      ST_ARMED:             o.status = STATUS_BLINK;
      ST_TRIGGERED:         o.status = STATUS_ON;
      ST_ALARM:             begin o.status = STATUS_ON; o.siren = 1'b1; end
      ST_DISARMED,
      ST_WAIT_DRIVER_OUT,
      ST_WAIT_DOORS_CLOSED,
      ST_ARMING:            o.status = STATUS_OFF;
      default:              o.status = STATUS_BLINK;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/seconds_timer.sv
// Seconds down-counter: loads on request, decrements on each tick while
// nonzero and holds at zero. A load in the same cycle as a tick wins.
module seconds_timer
  import anti_theft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               tick,
  output logic [TIMER_W-1:0] count,
  output logic               expired
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: load has priority, otherwise saturating decrement on tick.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == '0);

endmodule

// File: rtl/anti_theft_controller.sv
// Central anti-theft FSM. Ignition, door levels and the shared 1 Hz strobe
// drive the state; the LED status code, siren and countdown come straight
// from the state and timer registers. one_hz_enable is a bare one-cycle
// strobe with no handshake: it is consumed in the cycle it is high.
module anti_theft_controller
  import anti_theft_pkg::*;
#(
  parameter int T_ARM_DELAY       = 6,
  parameter int T_DRIVER_DELAY    = 8,
  parameter int T_PASSENGER_DELAY = 15,
  parameter int T_ALARM_ON        = 10
) (
  input  logic               clock_25mhz,
  input  logic               reset_sync,
  input  logic               one_hz_enable,
  input  logic               ignition,
  input  logic               driver_door,
  input  logic               passenger_door,
  output logic [1:0]         status_indicator_led_status,
  output logic               siren,
  output logic [TIMER_W-1:0] timer_remaining,
  output logic [2:0]         state_dbg
);

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_expired;
  logic               any_door;
  out_t               dec;

  assign any_door = driver_door || passenger_door;

  // Next-state and timer-load selection; ignition overrides everything
  // except when already disarmed.
  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_value = '0;
    if (ignition && (state_q != ST_DISARMED)) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (driver_door) begin
            state_d     = ST_TRIGGERED;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(T_DRIVER_DELAY);
          end else if (passenger_door) begin
            state_d     = ST_TRIGGERED;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(T_PASSENGER_DELAY);
          end
        end
        ST_TRIGGERED: begin
          if (timer_expired) begin
            state_d     = ST_ALARM;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(T_ALARM_ON);
          end
        end
        ST_ALARM: begin
          if (any_door) begin
            timer_load  = 1'b1;
            timer_value = TIMER_W'(T_ALARM_ON);
          end else if (timer_expired) begin
            state_d = ST_ARMED;
          end
        end
        ST_DISARMED: begin
          if (!ignition) state_d = ST_WAIT_DRIVER_OUT;
        end
        ST_WAIT_DRIVER_OUT: begin
          if (driver_door) state_d = ST_WAIT_DOORS_CLOSED;
        end
        ST_WAIT_DOORS_CLOSED: begin
          if (!any_door) begin
            state_d     = ST_ARMING;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(T_ARM_DELAY);
          end
        end
        ST_ARMING: begin
          if (any_door) begin
            state_d = ST_WAIT_DOORS_CLOSED;
          end else if (timer_expired) begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  // State register; reset lands in ARMED.
  always_ff @(posedge clock_25mhz or posedge reset_sync) begin
    if (reset_sync) begin
      state_q <= ST_ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  seconds_timer u_timer (
    .clk        (clock_25mhz),
    .rst        (reset_sync),
    .load       (timer_load),
    .load_value (timer_value),
    .tick       (one_hz_enable),
    .count      (timer_remaining),
    .expired    (timer_expired)
  );

  assign dec                         = decode_state(state_q);
  assign status_indicator_led_status = dec.status;
  assign siren                       = dec.siren;
  assign state_dbg                   = state_q;

endmodule

// File: tb/tb_anti_theft_controller.sv
// Directed bench for anti_theft_controller: a per-clock vector table plus
// hand-written multi-second sequences. Inputs change #1 after the rising
// edge and outputs are checked at that same point.
module tb_anti_theft_controller;
  import anti_theft_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clock_25mhz = 1'b0;
  logic       reset_sync  = 1'b1;
  logic       one_hz_enable = 1'b0;
  logic       ignition = 1'b0;
  logic       driver_door = 1'b0;
  logic       passenger_door = 1'b0;

  logic [1:0] status;
  logic       siren;
  logic [3:0] timer_remaining;
  logic [2:0] state_dbg;
  logic [1:0] status0;
  logic       siren0;
  logic [3:0] timer0;
  logic [2:0] state0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock_25mhz = ~clock_25mhz;

  anti_theft_controller u_dut (
    .clock_25mhz                 (clock_25mhz),
    .reset_sync                  (reset_sync),
    .one_hz_enable               (one_hz_enable),
    .ignition                    (ignition),
    .driver_door                 (driver_door),
    .passenger_door              (passenger_door),
    .status_indicator_led_status (status),
    .siren                       (siren),
    .timer_remaining             (timer_remaining),
    .state_dbg                   (state_dbg)
  );

  // Variant with a zero arming delay, sharing the same inputs.
  anti_theft_controller #(.T_ARM_DELAY(0)) u_dut0 (
    .clock_25mhz                 (clock_25mhz),
    .reset_sync                  (reset_sync),
    .one_hz_enable               (one_hz_enable),
    .ignition                    (ignition),
    .driver_door                 (driver_door),
    .passenger_door              (passenger_door),
    .status_indicator_led_status (status0),
    .siren                       (siren0),
    .timer_remaining             (timer0),
    .state_dbg                   (state0)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [1:0] st, input logic sr,
                           input logic [3:0] tm, input logic [2:0] fsm);
    check({name, ".status"}, {6'd0, status}, {6'd0, st});
    check({name, ".siren"},  {7'd0, siren},  {7'd0, sr});
    check({name, ".timer"},  {4'd0, timer_remaining}, {4'd0, tm});
    check({name, ".state"},  {5'd0, state_dbg}, {5'd0, fsm});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock_25mhz);
    #1;
  endtask

  // One second: three idle clocks then a strobe clock.
  task automatic second();
    one_hz_enable = 1'b0;
    repeat (3) step();
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
  endtask

  task automatic seconds(input int n);
    for (int i = 0; i < n; i++) second();
  endtask

  task automatic do_reset();
    ignition = 1'b0; driver_door = 1'b0; passenger_door = 1'b0; one_hz_enable = 1'b0;
    reset_sync = 1'b1;
    step();
    step();
    reset_sync = 1'b0;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ign;
    logic       drv;
    logic       pas;
    logic       tick;
    logic [1:0] st;
    logic       sr;
    logic [3:0] tm;
    logic [2:0] fsm;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Per-clock vectors starting from ARMED with a zero count.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, STATUS_BLINK, 1'b0, 4'd0,  ST_ARMED};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, STATUS_BLINK, 1'b0, 4'd0,  ST_ARMED};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, STATUS_ON,    1'b0, 4'd15, ST_TRIGGERED};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, STATUS_ON,    1'b0, 4'd14, ST_TRIGGERED};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, STATUS_ON,    1'b0, 4'd14, ST_TRIGGERED};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, STATUS_OFF,   1'b0, 4'd14, ST_DISARMED};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, STATUS_OFF,   1'b0, 4'd13, ST_DISARMED};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, STATUS_OFF,   1'b0, 4'd13, ST_WAIT_DRIVER_OUT};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, STATUS_OFF,   1'b0, 4'd13, ST_WAIT_DRIVER_OUT};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, STATUS_OFF,   1'b0, 4'd13, ST_WAIT_DOORS_CLOSED};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, STATUS_OFF,   1'b0, 4'd13, ST_WAIT_DOORS_CLOSED};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, STATUS_OFF,   1'b0, 4'd6,  ST_ARMING};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, STATUS_OFF,   1'b0, 4'd5,  ST_ARMING};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, STATUS_OFF,   1'b0, 4'd5,  ST_DISARMED};

    // Reset state, sampled while reset is still asserted.
    #1;
    check_out("reset_init", STATUS_BLINK, 1'b0, 4'd0, ST_ARMED);
    step();
    reset_sync = 1'b0;
    step();

    // Table-driven pass.
    for (int i = 0; i < 14; i++) begin
      ignition       = vecs[i].ign;
      driver_door    = vecs[i].drv;
      passenger_door = vecs[i].pas;
      one_hz_enable  = vecs[i].tick;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].sr, vecs[i].tm, vecs[i].fsm);
    end
    one_hz_enable = 1'b0;

    // Zero arming delay: ARMING leaves one clock after entry, no tick.
    do_reset();
    ignition = 1'b1; step();
    ignition = 1'b0; step();
    driver_door = 1'b1; step();
    driver_door = 1'b0; step();
    check("arm0.entry_state", {5'd0, state0}, {5'd0, ST_ARMING});
    check("arm0.entry_timer", {4'd0, timer0}, 8'd0);
    step();
    check("arm0.exit_state",  {5'd0, state0}, {5'd0, ST_ARMED});
    check("arm0.exit_status", {6'd0, status0}, {6'd0, STATUS_BLINK});
    check("arm0.siren",       {7'd0, siren0}, 8'd0);

    // Driver door while armed: 8 s grace then alarm with 10 s.
    do_reset();
    driver_door = 1'b1; step();
    driver_door = 1'b0;
    check_out("drv.trig", STATUS_ON, 1'b0, 4'd8, ST_TRIGGERED);
    seconds(3);
    check_out("drv.t5", STATUS_ON, 1'b0, 4'd5, ST_TRIGGERED);
    seconds(5);
    check_out("drv.t0", STATUS_ON, 1'b0, 4'd0, ST_TRIGGERED);
    step();
    check_out("drv.alarm", STATUS_ON, 1'b1, 4'd10, ST_ALARM);
    second();
    check_out("drv.alarm9", STATUS_ON, 1'b1, 4'd9, ST_ALARM);

    // Asynchronous reset in the middle of a clock while in ALARM.
    #3;
    reset_sync = 1'b1;
    #1;
    check_out("rst_mid", STATUS_BLINK, 1'b0, 4'd0, ST_ARMED);
    step();
    reset_sync = 1'b0;
    step();
    step();
    check_out("rst_after", STATUS_BLINK, 1'b0, 4'd0, ST_ARMED);
    second();
    check_out("rst_after_tick", STATUS_BLINK, 1'b0, 4'd0, ST_ARMED);

    // Both doors in the same cycle use the driver delay; ignition cancels.
    driver_door = 1'b1; passenger_door = 1'b1; step();
    driver_door = 1'b0; passenger_door = 1'b0;
    check_out("both.trig", STATUS_ON, 1'b0, 4'd8, ST_TRIGGERED);
    seconds(5);
    check("both.t3", {4'd0, timer_remaining}, 8'd3);
    ignition = 1'b1; step();
    check_out("both.ign", STATUS_OFF, 1'b0, 4'd3, ST_DISARMED);

    // Re-arm, trigger, and exercise the alarm reload.
    ignition = 1'b0; step();
    driver_door = 1'b1; step();
    driver_door = 1'b0; step();
    check_out("rearm.arming", STATUS_OFF, 1'b0, 4'd6, ST_ARMING);
    seconds(6);
    step();
    check_out("rearm.armed", STATUS_BLINK, 1'b0, 4'd0, ST_ARMED);
    driver_door = 1'b1; step();
    driver_door = 1'b0;
    seconds(8);
    step();
    check_out("alm.enter", STATUS_ON, 1'b1, 4'd10, ST_ALARM);
    seconds(6);
    check_out("alm.t4", STATUS_ON, 1'b1, 4'd4, ST_ALARM);
    passenger_door = 1'b1; step();
    check_out("alm.reload", STATUS_ON, 1'b1, 4'd10, ST_ALARM);
    second();
    check("alm.hold_open", {4'd0, timer_remaining}, 8'd10);
    passenger_door = 1'b0;
    seconds(10);
    check_out("alm.t0", STATUS_ON, 1'b1, 4'd0, ST_ALARM);
    step();
    check_out("alm.done", STATUS_BLINK, 1'b0, 4'd0, ST_ARMED);

    // Disarm/arm with a door reopening during ARMING.
    ignition = 1'b1; step();
    ignition = 1'b0; step();
    check_out("seq.wdo", STATUS_OFF, 1'b0, 4'd0, ST_WAIT_DRIVER_OUT);
    driver_door = 1'b1; step();
    driver_door = 1'b0; step();
    check_out("seq.arming", STATUS_OFF, 1'b0, 4'd6, ST_ARMING);
    seconds(4);
    check("seq.t2", {4'd0, timer_remaining}, 8'd2);
    passenger_door = 1'b1; step();
    check_out("seq.reopen", STATUS_OFF, 1'b0, 4'd2, ST_WAIT_DOORS_CLOSED);
    passenger_door = 1'b0; step();
    check_out("seq.reload", STATUS_OFF, 1'b0, 4'd6, ST_ARMING);
    seconds(6);
    check("seq.t0_state", {5'd0, state_dbg}, {5'd0, ST_ARMING});
    step();
    check_out("seq.armed", STATUS_BLINK, 1'b0, 4'd0, ST_ARMED);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
